// File: rtl/alu_op_sequencer_if.sv
// Issue/result handshake bundle for alu_op_sequencer.
// Upstream op fields travel with in_valid; results travel with out_valid.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_taken;
  logic              out_overflow;
  logic              out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct3,
    output in_funct7b5, in_a, in_b,
    input  in_ready,
    input  out_valid, out_result, out_taken,
    input  out_overflow, out_illegal,
    output out_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3,
    input  in_funct7b5, in_a, in_b,
    output in_ready,
    output out_valid, out_result, out_taken,
    output out_overflow, out_illegal,
    input  out_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side ALU driver: decodes RV32I arithmetic/branch ops into
// ALU passes, runs unsigned compares as 3-pass biased subtracts.
module alu_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int SA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave io,
  output logic [OP_W-1:0]   alu_op,
  output logic [SA_W-1:0]   alu_sa,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_v
);

  localparam logic [OP_W-1:0] A_OR  = 4'b0001;
  localparam logic [OP_W-1:0] A_AND = 4'b0011;
  localparam logic [OP_W-1:0] A_XOR = 4'b0111;
  localparam logic [OP_W-1:0] A_EQ  = 4'b0010;
  localparam logic [OP_W-1:0] A_NE  = 4'b0000;
  localparam logic [OP_W-1:0] A_ADD = 4'b1000;
  localparam logic [OP_W-1:0] A_SUB = 4'b1100;
  localparam logic [OP_W-1:0] A_SLL = 4'b1010;
  localparam logic [OP_W-1:0] A_SRL = 4'b1110;
  localparam logic [OP_W-1:0] A_SRA = 4'b1111;

  localparam logic [DATA_W-1:0] BIAS =
    {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUI = 7'b0010111;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE, EXEC1, EXEC2, EXEC3, DONE
  } state_e;

  typedef enum logic [3:0] {
    K_PLAIN, K_ADDSUB, K_SLT, K_BEQ, K_BLT,
    K_BGE, K_SLTU, K_BLTU, K_BGEU
  } kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [SA_W-1:0]   alu_sa_q, alu_sa_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              taken_q, taken_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;

  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  kind_e             dec_kind;
  logic              dec_ill;

  logic [DATA_W-1:0] fin_res;
  logic              fin_taken;
  logic              fin_ovf;
  logic              lt;
  logic              three_pass;

  always_comb begin
    dec_op   = A_ADD;
    dec_a    = io.in_a;
    dec_b    = io.in_b;
    dec_kind = K_PLAIN;
    dec_ill  = 1'b0;
    case (io.in_opcode)
      OPC_OP, OPC_IMM: begin
        case (io.in_funct3)
          3'b000: begin
            dec_kind = K_ADDSUB;
            if (io.in_opcode == OPC_OP && io.in_funct7b5)
              dec_op = A_SUB;
          end
          3'b001: dec_op = A_SLL;
          3'b010: begin
            dec_op   = A_SUB;
            dec_kind = K_SLT;
          end
          3'b011: begin
            dec_op   = A_XOR;
            dec_b    = BIAS;
            dec_kind = K_SLTU;
          end
          3'b100: dec_op = A_XOR;
          3'b101: dec_op = io.in_funct7b5 ? A_SRA : A_SRL;
          3'b110: dec_op = A_OR;
          default: dec_op = A_AND;
        endcase
      end
      OPC_LUI: dec_a = '0;
      OPC_AUI: dec_op = A_ADD;
      OPC_BR: begin
        case (io.in_funct3)
          3'b000: begin
            dec_op   = A_EQ;
            dec_kind = K_BEQ;
          end
          3'b001: begin
            dec_op   = A_NE;
            dec_kind = K_BEQ;
          end
          3'b100: begin
            dec_op   = A_SUB;
            dec_kind = K_BLT;
          end
          3'b101: begin
            dec_op   = A_SUB;
            dec_kind = K_BGE;
          end
          3'b110: begin
            dec_op   = A_XOR;
            dec_b    = BIAS;
            dec_kind = K_BLTU;
          end
          3'b111: begin
            dec_op   = A_XOR;
            dec_b    = BIAS;
            dec_kind = K_BGEU;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign lt = alu_c[DATA_W-1] ^ alu_v;
  assign three_pass = (kind_q == K_SLTU) ||
                      (kind_q == K_BLTU) ||
                      (kind_q == K_BGEU);

  always_comb begin
    fin_res   = alu_c;
    fin_taken = 1'b0;
    fin_ovf   = 1'b0;
    case (kind_q)
      K_ADDSUB: fin_ovf = alu_v;
      K_SLT, K_SLTU:
        fin_res = {{(DATA_W-1){1'b0}}, lt};
      K_BEQ: fin_taken = alu_c[0];
      K_BLT, K_BLTU: fin_taken = lt;
      K_BGE, K_BGEU: fin_taken = ~lt;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    alu_op_d = alu_op_q;
    alu_sa_d = alu_sa_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    taken_d  = taken_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          if (dec_ill) begin
            res_d   = '0;
            taken_d = 1'b0;
            ovf_d   = 1'b0;
            ill_d   = 1'b1;
            state_d = DONE;
          end else begin
            alu_op_d = dec_op;
            alu_sa_d = io.in_b[SA_W-1:0];
            alu_a_d  = dec_a;
            alu_b_d  = dec_b;
            kind_d   = dec_kind;
            opnd_d   = io.in_b;
            ill_d    = 1'b0;
            state_d  = EXEC1;
          end
        end
      end
      EXEC1: begin
        if (three_pass) begin
          // Keep biased A; bias original B next.
          alu_a_d = opnd_q;
          alu_b_d = BIAS;
          opnd_d  = alu_c;
          state_d = EXEC2;
        end else begin
          res_d   = fin_res;
          taken_d = fin_taken;
          ovf_d   = fin_ovf;
          state_d = DONE;
        end
      end
      EXEC2: begin
        alu_op_d = A_SUB;
        alu_a_d  = opnd_q;
        alu_b_d  = alu_c;
        state_d  = EXEC3;
      end
      EXEC3: begin
        res_d   = fin_res;
        taken_d = fin_taken;
        ovf_d   = fin_ovf;
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      kind_q   <= K_PLAIN;
      alu_op_q <= '0;
      alu_sa_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
      taken_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      alu_op_q <= alu_op_d;
      alu_sa_q <= alu_sa_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      taken_q  <= taken_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign alu_op          = alu_op_q;
  assign alu_sa          = alu_sa_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign io.in_ready     = (state_q == IDLE);
  assign io.out_valid    = (state_q == DONE);
  assign io.out_result   = res_q;
  assign io.out_taken    = taken_q;
  assign io.out_overflow = ovf_q;
  assign io.out_illegal  = ill_q;

endmodule
